// File: rtl/kmeans_pipeline_param.sv
// rtl/kmeans_pipeline_param.sv - parametrised K-centroid, D-dimension nearest-centroid classifier
// Optional per-centroid accumulators (acc_* ports) are built when KMEANS_ACC_EN is defined.
module kmeans_pipeline_param #(
  parameter int DATA_W = 16,
  parameter int K      = 4,
  parameter int D      = 3,
  parameter int IDX_W  = (K > 1) ? $clog2(K) : 1,
  parameter int DIM_W  = (D > 1) ? $clog2(D) : 1,
  parameter int DIST_W = 2 * DATA_W + $clog2(D)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cent_wr_en,
  input  logic [IDX_W-1:0]           cent_wr_k,
  input  logic [DIM_W-1:0]           cent_wr_d,
  input  logic [DATA_W-1:0]          cent_wr_data,
  input  logic                       in_valid,
  input  logic [D*DATA_W-1:0]        in_data,
  output logic                       out_valid,
  output logic [D*DATA_W-1:0]        out_data,
  output logic [IDX_W-1:0]           out_idx,
  output logic [DIST_W-1:0]          out_dist
`ifdef KMEANS_ACC_EN
  ,
  input  logic                       acc_clr,
  input  logic [IDX_W-1:0]           acc_rd_k,
  input  logic [DIM_W-1:0]           acc_rd_d,
  output logic [DATA_W+15:0]         acc_rd_sum,
  output logic [15:0]                acc_rd_cnt,
  output logic                       acc_ovf
`endif
);

  localparam int LD   = $clog2(D);
  localparam int LK   = $clog2(K);
  localparam int L    = 2 + LD + LK;
  localparam int NA   = (LD > 0) ? LD : 1;
  localparam int LDI  = (LD > 0) ? LD - 1 : 0;
  localparam int SQ_W = 2 * DATA_W;

  logic [DATA_W-1:0]   cent_q   [K][D];
  logic [DATA_W-1:0]   cent_d   [K][D];
  logic [L-1:0]        vld_q, vld_d;
  logic [DATA_W-1:0]   diff_q   [K][D];
  logic [DATA_W-1:0]   diff_d   [K][D];
  logic [SQ_W-1:0]     sq_q     [K][D];
  logic [SQ_W-1:0]     sq_d     [K][D];
  logic [DIST_W-1:0]   add_q    [NA][K][D];
  logic [DIST_W-1:0]   add_d    [NA][K][D];
  logic [DIST_W-1:0]   cmp_dist_q [LK][K];
  logic [DIST_W-1:0]   cmp_dist_d [LK][K];
  logic [IDX_W-1:0]    cmp_idx_q  [LK][K];
  logic [IDX_W-1:0]    cmp_idx_d  [LK][K];
  logic [D*DATA_W-1:0] dly_q    [L];
  logic [D*DATA_W-1:0] dly_d    [L];
  logic [DIST_W-1:0]   dist_k   [K];

  always_comb begin
    int n;
    int pl;
    int a;
    int b;
    logic [DIST_W-1:0] sa;
    logic [DIST_W-1:0] sb;
    logic [IDX_W-1:0]  ia;
    logic [IDX_W-1:0]  ib;
    n  = 0;
    pl = 0;
    a  = 0;
    b  = 0;
    sa = '0;
    sb = '0;
    ia = '0;
    ib = '0;

    // Out-of-range write indices match no entry, so they fall away naturally.
    // cent_d doubles as the write-through view used by a same-cycle sample.
    cent_d = cent_q;
    for (int k = 0; k < K; k++)
      for (int d = 0; d < D; d++)
        if (cent_wr_en && 32'(cent_wr_k) == k && 32'(cent_wr_d) == d)
          cent_d[k][d] = cent_wr_data;

    vld_d = {vld_q[L-2:0], in_valid};

    diff_d = diff_q;
    if (in_valid)
      for (int k = 0; k < K; k++)
        for (int d = 0; d < D; d++)
          diff_d[k][d] = (cent_d[k][d] > in_data[d*DATA_W +: DATA_W])
                       ? cent_d[k][d] - in_data[d*DATA_W +: DATA_W]
                       : in_data[d*DATA_W +: DATA_W] - cent_d[k][d];

    sq_d = sq_q;
    if (vld_q[0])
      for (int k = 0; k < K; k++)
        for (int d = 0; d < D; d++)
          sq_d[k][d] = SQ_W'(diff_q[k][d]) * SQ_W'(diff_q[k][d]);

    add_d = add_q;
    n = D;
    for (int l = 0; l < LD; l++) begin
      pl = (l > 0) ? l - 1 : 0;
      if (vld_q[1+l])
        for (int k = 0; k < K; k++)
          for (int i = 0; i < D; i++) begin
            a = (2 * i < D) ? 2 * i : 0;
            b = (2 * i + 1 < D) ? 2 * i + 1 : 0;
            if (l == 0) begin
              sa = DIST_W'(sq_q[k][a]);
              sb = DIST_W'(sq_q[k][b]);
            end else begin
              sa = add_q[pl][k][a];
              sb = add_q[pl][k][b];
            end
            if (2 * i + 1 < n)
              add_d[l][k][i] = sa + sb;
            else if (2 * i < n)
              add_d[l][k][i] = sa;
          end
      n = (n + 1) / 2;
    end

    for (int k = 0; k < K; k++)
      dist_k[k] = (LD == 0) ? DIST_W'(sq_q[k][0]) : add_q[LDI][k][0];

    // Lower-index operand sits on the left, so a tie keeps it.
    cmp_dist_d = cmp_dist_q;
    cmp_idx_d  = cmp_idx_q;
    n = K;
    for (int l = 0; l < LK; l++) begin
      pl = (l > 0) ? l - 1 : 0;
      if (vld_q[1+LD+l])
        for (int i = 0; i < K; i++) begin
          a = (2 * i < K) ? 2 * i : 0;
          b = (2 * i + 1 < K) ? 2 * i + 1 : 0;
          if (l == 0) begin
            sa = dist_k[a];
            sb = dist_k[b];
            ia = IDX_W'(a);
            ib = IDX_W'(b);
          end else begin
            sa = cmp_dist_q[pl][a];
            sb = cmp_dist_q[pl][b];
            ia = cmp_idx_q[pl][a];
            ib = cmp_idx_q[pl][b];
          end
          if (2 * i + 1 < n && sb < sa) begin
            cmp_dist_d[l][i] = sb;
            cmp_idx_d[l][i]  = ib;
          end else if (2 * i < n) begin
            cmp_dist_d[l][i] = sa;
            cmp_idx_d[l][i]  = ia;
          end
        end
      n = (n + 1) / 2;
    end

    dly_d[0] = in_valid ? in_data : dly_q[0];
    for (int s = 1; s < L; s++)
      dly_d[s] = vld_q[s-1] ? dly_q[s-1] : dly_q[s];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < K; k++) begin
        for (int d = 0; d < D; d++) begin
          cent_q[k][d] <= '0;
          diff_q[k][d] <= '0;
          sq_q[k][d]   <= '0;
          for (int l = 0; l < NA; l++)
            add_q[l][k][d] <= '0;
        end
        for (int l = 0; l < LK; l++) begin
          cmp_dist_q[l][k] <= '0;
          cmp_idx_q[l][k]  <= '0;
        end
      end
      for (int s = 0; s < L; s++)
        dly_q[s] <= '0;
    end else begin
      vld_q      <= vld_d;
      cent_q     <= cent_d;
      diff_q     <= diff_d;
      sq_q       <= sq_d;
      add_q      <= add_d;
      cmp_dist_q <= cmp_dist_d;
      cmp_idx_q  <= cmp_idx_d;
      dly_q      <= dly_d;
    end
  end

  assign out_valid = vld_q[L-1];
  assign out_data  = dly_q[L-1];
  assign out_idx   = cmp_idx_q[LK-1][0];
  assign out_dist  = cmp_dist_q[LK-1][0];

`ifdef KMEANS_ACC_EN
  localparam int ACC_W = DATA_W + 16;

  logic [ACC_W-1:0] sum_q [K][D];
  logic [ACC_W-1:0] sum_d [K][D];
  logic [15:0]      cnt_q [K];
  logic [15:0]      cnt_d [K];
  logic             ovf_q, ovf_d;

  // A saturated count drops the whole sample so sum/cnt stay a consistent mean.
  always_comb begin
    sum_d = sum_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (acc_clr) begin
      ovf_d = 1'b0;
      for (int k = 0; k < K; k++) begin
        cnt_d[k] = '0;
        for (int d = 0; d < D; d++)
          sum_d[k][d] = '0;
      end
    end else if (out_valid) begin
      for (int k = 0; k < K; k++)
        if (32'(out_idx) == k) begin
          if (cnt_q[k] == 16'hFFFF) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d[k] = cnt_q[k] + 16'd1;
            for (int d = 0; d < D; d++)
              sum_d[k][d] = sum_q[k][d] + ACC_W'(out_data[d*DATA_W +: DATA_W]);
          end
        end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      for (int k = 0; k < K; k++) begin
        cnt_q[k] <= '0;
        for (int d = 0; d < D; d++)
          sum_q[k][d] <= '0;
      end
    end else begin
      sum_q <= sum_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  always_comb begin
    acc_rd_sum = '0;
    acc_rd_cnt = '0;
    for (int k = 0; k < K; k++)
      if (32'(acc_rd_k) == k) begin
        acc_rd_cnt = cnt_q[k];
        for (int d = 0; d < D; d++)
          if (32'(acc_rd_d) == d)
            acc_rd_sum = sum_q[k][d];
      end
  end

  assign acc_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_kmeans_pipeline_param.sv
// tb/tb_kmeans_pipeline_param.sv - directed self-checking bench for kmeans_pipeline_param (K=2, D=3)
module tb_kmeans_pipeline_param;

  localparam int DATA_W = 16;
  localparam int K      = 2;
  localparam int D      = 3;
  localparam int IDX_W  = 1;
  localparam int DIM_W  = 2;
  localparam int DIST_W = 34;
  localparam int L      = 5;
  localparam int RB     = 32;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                cent_wr_en = 1'b0;
  logic [IDX_W-1:0]    cent_wr_k = '0;
  logic [DIM_W-1:0]    cent_wr_d = '0;
  logic [DATA_W-1:0]   cent_wr_data = '0;
  logic                in_valid = 1'b0;
  logic [D*DATA_W-1:0] in_data = '0;
  logic                out_valid;
  logic [D*DATA_W-1:0] out_data;
  logic [IDX_W-1:0]    out_idx;
  logic [DIST_W-1:0]   out_dist;
`ifdef KMEANS_ACC_EN
  logic                acc_clr = 1'b0;
  logic [IDX_W-1:0]    acc_rd_k = '0;
  logic [DIM_W-1:0]    acc_rd_d = '0;
  logic [DATA_W+15:0]  acc_rd_sum;
  logic [15:0]         acc_rd_cnt;
  logic                acc_ovf;
`endif

  kmeans_pipeline_param #(.DATA_W(DATA_W), .K(K), .D(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .cent_wr_en(cent_wr_en), .cent_wr_k(cent_wr_k), .cent_wr_d(cent_wr_d),
    .cent_wr_data(cent_wr_data),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx), .out_dist(out_dist)
`ifdef KMEANS_ACC_EN
    , .acc_clr(acc_clr), .acc_rd_k(acc_rd_k), .acc_rd_d(acc_rd_d),
    .acc_rd_sum(acc_rd_sum), .acc_rd_cnt(acc_rd_cnt), .acc_ovf(acc_ovf)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  int          tb_cent [K][D];
  bit          rb_v    [RB];
  int          rb_idx  [RB];
  longint      rb_dist [RB];
  logic [47:0] rb_data [RB];
  int          cyc = 0;
  int          exp_in_idx = 0;
  longint      exp_in_dist = 0;
  int          last_idx = 0;
  longint      last_dist = 0;
  logic [47:0] last_data = '0;

  // Expectation for the sample sampled at each edge; a reset edge voids everything in flight.
  always @(posedge clk) begin
    rb_v[cyc % RB]    = in_valid && rst_n;
    rb_idx[cyc % RB]  = exp_in_idx;
    rb_dist[cyc % RB] = exp_in_dist;
    rb_data[cyc % RB] = in_data;
    if (!rst_n) begin
      for (int j = 1; j < L; j++)
        rb_v[(cyc + RB - j) % RB] = 1'b0;
      last_idx  = 0;
      last_dist = 0;
      last_data = '0;
    end
    cyc++;
  end

  always @(negedge clk) begin
    int e;
    if (cyc >= L) begin
      e = (cyc - L) % RB;
      check("out_valid", out_valid, rb_v[e]);
      if (rb_v[e]) begin
        last_idx  = rb_idx[e];
        last_dist = rb_dist[e];
        last_data = rb_data[e];
      end
      check("out_idx", out_idx, last_idx);
      check("out_dist", out_dist, last_dist);
      check("out_data", out_data, last_data);
    end
  end

  task automatic set_wr(input int k, input int d, input int val);
    cent_wr_en   = 1'b1;
    cent_wr_k    = IDX_W'(k);
    cent_wr_d    = DIM_W'(d);
    cent_wr_data = DATA_W'(val);
    if (k < K && d < D) tb_cent[k][d] = val;
  endtask

  task automatic drive(input bit v, input int x0, input int x1, input int x2,
                       input int ei, input longint ed);
    in_valid    = v;
    in_data     = {16'(x2), 16'(x1), 16'(x0)};
    exp_in_idx  = ei;
    exp_in_dist = ed;
    @(negedge clk);
    cent_wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 0, 0, 0);
  endtask

  task automatic set_cent(input int k, input int a, input int b, input int c);
    set_wr(k, 0, a); idle(1);
    set_wr(k, 1, b); idle(1);
    set_wr(k, 2, c); idle(1);
  endtask

  task automatic model(input int x0, input int x1, input int x2,
                       output int ei, output longint ed);
    int     xs [D];
    longint dd;
    longint df;
    xs = '{x0, x1, x2};
    ei = 0;
    ed = 0;
    for (int k = 0; k < K; k++) begin
      dd = 0;
      for (int d = 0; d < D; d++) begin
        df = longint'(tb_cent[k][d]) - longint'(xs[d]);
        dd += df * df;
      end
      if (k == 0 || dd < ed) begin
        ei = k;
        ed = dd;
      end
    end
  endtask

  task automatic drive_m(input bit v, input int x0, input int x1, input int x2);
    int     ei;
    longint ed;
    model(x0, x1, x2, ei, ed);
    drive(v, x0, x1, x2, ei, ed);
  endtask

  initial begin
    for (int k = 0; k < K; k++)
      for (int d = 0; d < D; d++)
        tb_cent[k][d] = 0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_dist", out_dist, 0);
    check("rst_out_data", out_data, 0);
    rst_n = 1'b1;

    set_cent(1, 10, 10, 10);
    drive(1'b1, 9, 9, 9, 1, 3);
    drive(1'b1, 2, 1, 0, 0, 5);

    set_cent(0, 100, 100, 100);
    set_cent(1, 0, 0, 0);
    drive(1'b1, 90, 90, 90, 0, 300);
    drive(1'b1, 5, 5, 5, 1, 75);

    set_cent(0, 4, 4, 4);
    set_cent(1, 6, 6, 6);
    drive(1'b1, 5, 5, 5, 0, 3);

    set_cent(0, 10, 20, 30);
    set_cent(1, 60, 40, 20);
    for (int i = 0; i < 20; i++)
      drive_m(!(i == 3 || i == 7), i * 7, i * 3 + 1, 50 - i);

    set_cent(0, 0, 0, 0);
    set_cent(1, 20, 0, 0);
    drive(1'b1, 12, 0, 0, 1, 64);
    drive(1'b1, 12, 0, 0, 1, 64);
    set_wr(1, 0, 100);
    drive(1'b1, 12, 0, 0, 0, 144);
    drive(1'b1, 12, 0, 0, 0, 144);

    set_wr(0, 3, 999);
    drive(1'b1, 3, 0, 0, 0, 9);

    drive(1'b1, 1, 1, 1, 0, 3);
    drive(1'b1, 1, 1, 1, 0, 3);
    drive(1'b1, 1, 1, 1, 0, 3);
    rst_n = 1'b0;
    drive(1'b1, 1, 1, 1, 0, 3);
    rst_n = 1'b1;
    for (int k = 0; k < K; k++)
      for (int d = 0; d < D; d++)
        tb_cent[k][d] = 0;
    idle(2);
    drive(1'b1, 1, 2, 3, 0, 14);
    idle(L + 2);

`ifdef KMEANS_ACC_EN
    set_cent(1, 100, 100, 100);
    idle(L);
    acc_clr = 1'b1;
    idle(1);
    acc_clr = 1'b0;
    drive(1'b1, 1, 100, 100, 1, 9801);
    drive(1'b1, 2, 100, 100, 1, 9604);
    drive(1'b1, 3, 100, 100, 1, 9409);
    idle(L + 1);
    acc_rd_k = 1'b1;
    acc_rd_d = 2'd0;
    #1;
    check("acc_sum_d0", acc_rd_sum, 6);
    check("acc_cnt", acc_rd_cnt, 3);
    check("acc_ovf_clear", acc_ovf, 0);
    acc_rd_d = 2'd1;
    #1;
    check("acc_sum_d1", acc_rd_sum, 300);

    drive(1'b1, 1, 100, 100, 1, 9801);
    idle(L - 1);
    check("acc_clr_out_valid", out_valid, 1);
    acc_clr = 1'b1;
    idle(1);
    acc_clr = 1'b0;
    acc_rd_d = 2'd0;
    #1;
    check("acc_clr_sum", acc_rd_sum, 0);
    check("acc_clr_cnt", acc_rd_cnt, 0);

    for (int i = 0; i < 65535; i++) drive(1'b1, 1, 100, 100, 1, 9801);
    idle(L + 1);
    #1;
    check("acc_full_cnt", acc_rd_cnt, 16'hFFFF);
    check("acc_full_sum", acc_rd_sum, 65535);
    check("acc_full_ovf", acc_ovf, 0);
    drive(1'b1, 1, 100, 100, 1, 9801);
    idle(L + 1);
    #1;
    check("acc_ovf_set", acc_ovf, 1);
    check("acc_ovf_sum", acc_rd_sum, 65535);
    check("acc_ovf_cnt", acc_rd_cnt, 16'hFFFF);
    idle(2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
